id_ex_pipe_reg: RTL and testbench

Parametrised decode-to-execute pipeline register for the pipelined ARM core. It replaces the fixed-width, always-loading ID/EX register with:
- configurable control width and number of data channels
- stall (hold) and flush (bubble insertion)
- a per-stage valid bit
- saturating stall and bubble counters for performance debug

It sits between the decode stage and the execute stage. The hazard unit drives Stall and Flush.

---
 rtl/id_ex_pipe_reg.sv | 73 +++++++
 tb/tb_id_ex_pipe_reg.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with stall/flush, a stage valid bit and
// saturating stall/bubble counters for performance debug.
module id_ex_pipe_reg #(
    parameter int                 CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]  CTRL_RST = '0,
    parameter int                 DATA_W   = 32,
    parameter int                 NUM_DATA = 4,
    parameter int                 WA_W     = 4,
    parameter int                 CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         Stall,
    input  logic                         Flush,
    input  logic                         ClrCnt,
    input  logic                         ValidD,
    input  logic [CTRL_W-1:0]            CtrlD,
    input  logic [NUM_DATA*DATA_W-1:0]   DataD,
    input  logic [WA_W-1:0]              WA3D,
    output logic                         ValidE,
    output logic [CTRL_W-1:0]            CtrlE,
    output logic [NUM_DATA*DATA_W-1:0]   DataE,
    output logic [WA_W-1:0]              WA3E,
    output logic [CNT_W-1:0]             StallCount,
    output logic [CNT_W-1:0]             BubbleCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic stall_evt;
    logic bubble_evt;

    // Flush wins over Stall; a load of an empty decode slot is also a bubble.
    assign stall_evt  = Stall && !Flush;
    assign bubble_evt = Flush || (!Stall && !ValidD);

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ValidE <= 1'b0;
            CtrlE  <= CTRL_RST;
            DataE  <= '0;
            WA3E   <= '0;
        end else if (Flush) begin
            // NOTE: data and destination hold on a bubble; ValidE/CtrlE alone make it harmless.
            ValidE <= 1'b0;
            CtrlE  <= CTRL_RST;
        end else if (!Stall) begin
            ValidE <= ValidD;
            CtrlE  <= ValidD ? CtrlD : CTRL_RST;
            DataE  <= DataD;
            WA3E   <= WA3D;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            StallCount  <= '0;
            BubbleCount <= '0;
        end else if (ClrCnt) begin
            StallCount  <= '0;
            BubbleCount <= '0;
        end else begin
            if (stall_evt && (StallCount != CNT_MAX)) begin
                StallCount <= StallCount + CNT_W'(1);
            end
            if (bubble_evt && (BubbleCount != CNT_MAX)) begin
                BubbleCount <= BubbleCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: a full-width instance and a CNT_W=2
// instance share stimulus; expectations are queued per edge and popped after it.
module tb_id_ex_pipe_reg;

    localparam logic [15:0] RST_A = 16'h0100;

    typedef struct {
        logic         v;
        logic [15:0]  ctrl;
        logic [127:0] data;
        logic [3:0]   wa;
        logic [15:0]  sca;
        logic [15:0]  bca;
        logic [1:0]   scb;
        logic [1:0]   bcb;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         Stall, Flush, ClrCnt, ValidD;
    logic [15:0]  CtrlD;
    logic [127:0] DataD;
    logic [3:0]   WA3D;

    logic         ValidE_a, ValidE_b;
    logic [15:0]  CtrlE_a, CtrlE_b;
    logic [127:0] DataE_a, DataE_b;
    logic [3:0]   WA3E_a, WA3E_b;
    logic [15:0]  StallCount_a, BubbleCount_a;
    logic [1:0]   StallCount_b, BubbleCount_b;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    exp_t m;

    id_ex_pipe_reg #(.CTRL_W(16), .CTRL_RST(RST_A), .DATA_W(32), .NUM_DATA(4),
                     .WA_W(4), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .Stall(Stall), .Flush(Flush), .ClrCnt(ClrCnt),
        .ValidD(ValidD), .CtrlD(CtrlD), .DataD(DataD), .WA3D(WA3D),
        .ValidE(ValidE_a), .CtrlE(CtrlE_a), .DataE(DataE_a), .WA3E(WA3E_a),
        .StallCount(StallCount_a), .BubbleCount(BubbleCount_a)
    );

    id_ex_pipe_reg #(.CTRL_W(16), .CTRL_RST(16'h0000), .DATA_W(32), .NUM_DATA(4),
                     .WA_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .Stall(Stall), .Flush(Flush), .ClrCnt(ClrCnt),
        .ValidD(ValidD), .CtrlD(CtrlD), .DataD(DataD), .WA3D(WA3D),
        .ValidE(ValidE_b), .CtrlE(CtrlE_b), .DataE(DataE_b), .WA3E(WA3E_b),
        .StallCount(StallCount_b), .BubbleCount(BubbleCount_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m.v = 1'b0; m.ctrl = RST_A; m.data = '0; m.wa = '0;
        m.sca = '0; m.bca = '0; m.scb = '0; m.bcb = '0;
    endtask

    // Advance the model on the current inputs, push, clock, then pop and compare.
    task automatic step();
        exp_t e;
        logic bub;
        bub = Flush || (!Stall && !ValidD);
        if (ClrCnt) begin
            m.sca = '0; m.bca = '0; m.scb = '0; m.bcb = '0;
        end else begin
            if (Stall && !Flush) begin
                if (m.sca != 16'hFFFF) m.sca = m.sca + 16'd1;
                if (m.scb != 2'd3)     m.scb = m.scb + 2'd1;
            end
            if (bub) begin
                if (m.bca != 16'hFFFF) m.bca = m.bca + 16'd1;
                if (m.bcb != 2'd3)     m.bcb = m.bcb + 2'd1;
            end
        end
        if (Flush) begin
            m.v = 1'b0; m.ctrl = RST_A;
        end else if (!Stall) begin
            m.v    = ValidD;
            m.ctrl = ValidD ? CtrlD : RST_A;
            m.data = DataD;
            m.wa   = WA3D;
        end
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("valid",   ValidE_a,      e.v);
        check("ctrl",    CtrlE_a,       e.ctrl);
        check("data",    DataE_a,       e.data);
        check("wa3",     WA3E_a,        e.wa);
        check("stall_a", StallCount_a,  e.sca);
        check("bub_a",   BubbleCount_a, e.bca);
        check("stall_b", StallCount_b,  e.scb);
        check("bub_b",   BubbleCount_b, e.bcb);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"},   ValidE_a,      1'b0);
        check({tag, "_ctrl"},    CtrlE_a,       RST_A);
        check({tag, "_ctrl_b"},  CtrlE_b,       16'h0000);
        check({tag, "_data"},    DataE_a,       '0);
        check({tag, "_wa3"},     WA3E_a,        '0);
        check({tag, "_stall_a"}, StallCount_a,  '0);
        check({tag, "_bub_a"},   BubbleCount_a, '0);
        check({tag, "_stall_b"}, StallCount_b,  '0);
        check({tag, "_bub_b"},   BubbleCount_b, '0);
    endtask

    task automatic drive(input logic v, input logic [15:0] c, input logic [127:0] d,
                         input logic [3:0] w, input logic s, input logic f, input logic cl);
        ValidD = v; CtrlD = c; DataD = d; WA3D = w; Stall = s; Flush = f; ClrCnt = cl;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check_reset_state("por");
        reset_n = 1'b1;

        // Plain load, channel 2 carries the marker word.
        drive(1'b1, 16'hA5C3, {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000},
              4'hB, 1'b0, 1'b0, 1'b0);
        step();
        check("load_ch2", DataE_a[64 +: 32], 32'hDEADBEEF);

        // Stall three cycles while decode inputs keep changing.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h1000 + 16'(i), {4{32'hC0DE0000 + 32'(i)}}, 4'(i), 1'b1, 1'b0, 1'b0);
            step();
            check("stall_hold_ctrl", CtrlE_a, 16'hA5C3);
        end
        check("stall_cnt3", StallCount_a, 16'd3);
        drive(1'b1, 16'h7E57, {4{32'h0BADF00D}}, 4'h7, 1'b0, 1'b0, 1'b0);
        step();
        check("post_stall_ctrl", CtrlE_a, 16'h7E57);

        // Flush together with Stall.
        drive(1'b1, 16'h5555, {4{32'hFFFFFFFF}}, 4'h2, 1'b1, 1'b1, 1'b0);
        step();
        check("flush_wa3", WA3E_a, 4'h7);

        // Invalid load with every control bit set.
        drive(1'b0, 16'hFFFF, {4{32'h12345678}}, 4'h9, 1'b0, 1'b0, 1'b0);
        step();
        check("inv_ctrl", CtrlE_a, RST_A);

        // Holding an already-empty stage is not a bubble.
        drive(1'b1, 16'h4242, '0, 4'h1, 1'b1, 1'b0, 1'b0);
        step();

        // Flush held for three cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h2222, {4{32'hAAAA0000 + 32'(i)}}, 4'h3, 1'b0, 1'b1, 1'b0);
            step();
        end

        // Saturation on the two-bit counters, then clear beating a stall.
        drive(1'b1, 16'h0F0F, '0, 4'h4, 1'b0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h0F0F, '0, 4'h4, 1'b1, 1'b0, 1'b0);
            step();
        end
        check("sat_b", StallCount_b, 2'd3);
        drive(1'b1, 16'h0F0F, '0, 4'h4, 1'b1, 1'b0, 1'b1);
        step();
        check("clr_b", StallCount_b, 2'd0);
        drive(1'b1, 16'h0F0F, '0, 4'h4, 1'b1, 1'b0, 1'b0);
        step();
        check("after_clr_b", StallCount_b, 2'd1);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, 4'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 15) == 0));
            step();
        end

        // Asynchronous reset in the middle of a stall, away from any edge.
        drive(1'b1, 16'h6666, {4{32'h66666666}}, 4'h6, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h7777, {4{32'h77777777}}, 4'h7, 1'b1, 1'b0, 1'b0);
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        model_reset();
        reset_n = 1'b1;
        drive(1'b1, 16'h9999, {4{32'h99999999}}, 4'h9, 1'b0, 1'b0, 1'b0);
        step();
        check("rst_recover_ctrl", CtrlE_a, 16'h9999);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
